// File: rtl/param_password_lock.sv
// Parameterized digit-entry password lock.
// Digits shift in MSB-first. A full entry is checked in a one-cycle CHECK
// state. Repeated wrong entries lead to a timed LOCKOUT. While unlocked, the
// password can be viewed, changed or the block relocked.
module param_password_lock #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_PASS = 16'h1234
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [DIGIT_W-1:0]                      digit,
  input  logic                                    enter,
  input  logic                                    set_pass,
  input  logic                                    view_pass,
  input  logic                                    lock,
  output logic                                    green_led,
  output logic                                    red_led,
  output logic                                    alarm,
  output logic [NUM_DIGITS*DIGIT_W-1:0]           viewed_pass,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]       attempts_left
);

  localparam int PW = NUM_DIGITS * DIGIT_W;
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_LOCKED, S_CHECK, S_UNLOCKED, S_SET_NEW, S_LOCKOUT
  } state_t;

  state_t          state, nstate;
  logic [PW-1:0]   entry, stored, entry_shift;
  logic [CW-1:0]   dcnt;
  logic [LW-1:0]   lcnt;
  logic            take, last_digit, match, to_locked, start_set;

  // A digit is taken only while collecting; lock wins over a digit in SET_NEW.
  assign take        = enter && ((state == S_LOCKED) || (state == S_SET_NEW && !lock));
  assign last_digit  = take && (dcnt == CW'(NUM_DIGITS - 1));
  assign entry_shift = (entry << DIGIT_W) | PW'(digit);
  assign match       = (entry == stored);
  assign to_locked   = (nstate == S_LOCKED) && (state != S_LOCKED);
  assign start_set   = (state == S_UNLOCKED) && set_pass && !lock;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LOCKED;
    else       state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      S_LOCKED:   if (last_digit) nstate = S_CHECK;
      S_CHECK: begin
        if (match)                         nstate = S_UNLOCKED;
        else if (attempts_left > AW'(1))   nstate = S_LOCKED;
        else                               nstate = S_LOCKOUT;
      end
      S_UNLOCKED: begin
        if (lock)          nstate = S_LOCKED;
        else if (set_pass) nstate = S_SET_NEW;
      end
      S_SET_NEW: begin
        if (lock)            nstate = S_LOCKED;
        else if (last_digit) nstate = S_UNLOCKED;
      end
      S_LOCKOUT:  if (lcnt == '0) nstate = S_LOCKED;
      default:    nstate = S_LOCKED;
    endcase
  end

  // Moore output decode.
  always_comb begin
    green_led = 1'b0;
    red_led   = 1'b0;
    alarm     = 1'b0;
    case (state)
      S_UNLOCKED, S_SET_NEW: green_led = 1'b1;
      S_LOCKOUT: begin red_led = 1'b1; alarm = 1'b1; end
      default:   red_led = 1'b1;
    endcase
  end

  // Entry shift register and digit counter; both clear on every entry to LOCKED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry <= '0;
      dcnt  <= '0;
    end else if (to_locked || start_set) begin
      entry <= '0;
      dcnt  <= '0;
    end else if (take) begin
      entry <= entry_shift;
      dcnt  <= last_digit ? '0 : dcnt + CW'(1);
    end
  end

  // Remaining wrong attempts: reloaded on match or lockout expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) attempts_left <= AW'(MAX_ATTEMPTS);
    else if (state == S_CHECK)
      attempts_left <= match ? AW'(MAX_ATTEMPTS)
                     : (attempts_left > AW'(1)) ? attempts_left - AW'(1) : '0;
    else if (state == S_LOCKOUT && lcnt == '0)
      attempts_left <= AW'(MAX_ATTEMPTS);
  end

  // Lockout down-counter: the state lasts LOCKOUT_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lcnt <= '0;
    else if (state == S_CHECK && nstate == S_LOCKOUT) lcnt <= LW'(LOCKOUT_CYCLES - 1);
    else if (state == S_LOCKOUT && lcnt != '0)        lcnt <= lcnt - LW'(1);
  end

  // Stored password: written on the edge that takes the final new digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stored <= DEFAULT_PASS;
    else if (state == S_SET_NEW && last_digit) stored <= entry_shift;
  end

  // Viewed password: latched on request, cleared whenever the block relocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) viewed_pass <= '0;
    else if (to_locked) viewed_pass <= '0;
    else if (state == S_UNLOCKED && view_pass && !lock && !set_pass) viewed_pass <= stored;
  end

endmodule

// File: tb/tb_param_password_lock.sv
// Bench for param_password_lock: default and 6-digit configurations, each
// run against a digit-queue reference model, plus directed scenarios.
module tb_param_password_lock;

  localparam int M_LK = 0, M_CHK = 1, M_UNL = 2, M_SET = 3, M_OUT = 4;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] digit;
  logic       enter, set_pass, view_pass, lock;

  logic        green_a, red_a, alarm_a, green_b, red_b, alarm_b;
  logic [15:0] vp_a;
  logic [23:0] vp_b;
  logic [1:0]  at_a, at_b;

  always #5 clk = ~clk;

  param_password_lock dut_a (
    .clk(clk), .reset(rst_a), .digit(digit), .enter(enter), .set_pass(set_pass),
    .view_pass(view_pass), .lock(lock), .green_led(green_a), .red_led(red_a),
    .alarm(alarm_a), .viewed_pass(vp_a), .attempts_left(at_a));

  param_password_lock #(.NUM_DIGITS(6), .DIGIT_W(4), .MAX_ATTEMPTS(2),
                        .LOCKOUT_CYCLES(16), .DEFAULT_PASS(24'h123456)) dut_b (
    .clk(clk), .reset(rst_b), .digit(digit), .enter(enter), .set_pass(set_pass),
    .view_pass(view_pass), .lock(lock), .green_led(green_b), .red_led(red_b),
    .alarm(alarm_b), .viewed_pass(vp_b), .attempts_left(at_b));

  int n_assert = 0, n_fail = 0;
  int sel;
  int N, W, MAXA, LCK;
  logic [63:0] DEF;

  // reference model
  int          mode, att, left;
  logic [63:0] pass, viewed, entry_val;
  int          q[$];

  logic        o_g, o_r, o_al;
  logic [63:0] o_vp;
  logic [1:0]  o_at;

  always_comb begin
    if (sel == 0) begin
      o_g = green_a; o_r = red_a; o_al = alarm_a; o_vp = 64'(vp_a); o_at = at_a;
    end else begin
      o_g = green_b; o_r = red_b; o_al = alarm_b; o_vp = 64'(vp_b); o_at = at_b;
    end
  end

  function automatic logic [63:0] qval();
    logic [63:0] v = 0;
    foreach (q[i]) v = v * (64'(1) << W) + 64'(q[i]);
    return v;
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mode = M_LK; att = MAXA; left = 0; pass = DEF; viewed = 0; q.delete();
  endtask

  task automatic model_step();
    case (mode)
      M_LK: if (enter) begin
        q.push_back(int'(digit));
        if (q.size() == N) begin entry_val = qval(); q.delete(); mode = M_CHK; end
      end
      M_CHK: begin
        if (entry_val == pass) begin mode = M_UNL; att = MAXA; end
        else if (att > 1) begin att--; mode = M_LK; end
        else begin att = 0; mode = M_OUT; left = LCK; end
      end
      M_UNL: begin
        if (lock) begin mode = M_LK; viewed = 0; end
        else if (set_pass) begin mode = M_SET; q.delete(); end
        else if (view_pass) viewed = pass;
      end
      M_SET: begin
        if (lock) begin mode = M_LK; q.delete(); viewed = 0; end
        else if (enter) begin
          q.push_back(int'(digit));
          if (q.size() == N) begin pass = qval(); q.delete(); mode = M_UNL; end
        end
      end
      default: begin
        left--;
        if (left == 0) begin mode = M_LK; att = MAXA; q.delete(); end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".green"}, 64'(o_g),  64'(mode == M_UNL || mode == M_SET));
    cmp({tag, ".red"},   64'(o_r),  64'(mode == M_LK || mode == M_CHK || mode == M_OUT));
    cmp({tag, ".alarm"}, 64'(o_al), 64'(mode == M_OUT));
    cmp({tag, ".view"},  o_vp,      viewed);
    cmp({tag, ".att"},   64'(o_at), 64'(att));
  endtask

  task automatic tick(input logic en, input logic [3:0] d, input logic st,
                      input logic vw, input logic lk);
    enter = en; digit = d; set_pass = st; view_pass = vw; lock = lk;
    @(posedge clk);
    model_step();
    #1;
    enter = 0; digit = 0; set_pass = 0; view_pass = 0; lock = 0;
    check_all("tick");
  endtask

  task automatic do_reset();
    if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
    #1;
    model_reset();
    cmp("rst.green", 64'(o_g), 64'(0));
    cmp("rst.red",   64'(o_r), 64'(1));
    cmp("rst.alarm", 64'(o_al), 64'(0));
    cmp("rst.view",  o_vp, 64'(0));
    cmp("rst.att",   64'(o_at), 64'(MAXA));
    @(posedge clk); #1;
    check_all("rst_hold");
    if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
  endtask

  task automatic enter_seq(input logic [63:0] val);
    for (int i = N - 1; i >= 0; i--) tick(1'b1, 4'(val >> (4 * i)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_directed();
    logic [63:0] bad;
    int cnt;
    bad = 0;
    for (int i = 0; i < N; i++) bad = bad * 16 + 9;
    do_reset();
    enter_seq(DEF);
    cmp("latency.green_in_check", 64'(o_g), 64'(0));
    tick(0, 0, 0, 0, 0);
    cmp("unlock.green", 64'(o_g), 64'(1));
    cmp("unlock.red",   64'(o_r), 64'(0));
    cmp("unlock.att",   64'(o_at), 64'(MAXA));
    tick(0, 0, 0, 1, 0);
    cmp("view.value", o_vp, DEF);
    tick(0, 0, 0, 0, 1);
    cmp("relock.view", o_vp, 64'(0));
    cmp("relock.red",  64'(o_r), 64'(1));
    for (int k = 1; k <= MAXA; k++) begin
      enter_seq(bad);
      tick(0, 0, 0, 0, 0);
      cmp("wrong.att", 64'(o_at), 64'(MAXA - k));
    end
    cmp("lockout.alarm", 64'(o_al), 64'(1));
    cnt = 1;
    for (int g = 0; g < 100; g++) begin
      tick(1, 4'd1, 0, 0, 0);
      if (o_al) cnt++; else break;
    end
    cmp("lockout.len", 64'(cnt), 64'(LCK));
    cmp("lockout.att_reload", 64'(o_at), 64'(MAXA));
    enter_seq(DEF);
    tick(0, 0, 0, 0, 0);
    cmp("post_lockout.unlock", 64'(o_g), 64'(1));
  endtask

  task automatic run_random(input int n);
    logic en, st, vw, lk;
    logic [3:0] d;
    repeat (n) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      else begin
        en = 1'($urandom_range(0, 1));
        d  = $urandom_range(0, 1) ? 4'(pass >> (4 * (N - 1 - (q.size() % N))))
                                  : 4'($urandom_range(0, 15));
        st = ($urandom_range(0, 7) == 0);
        vw = ($urandom_range(0, 7) == 0);
        lk = ($urandom_range(0, 11) == 0);
        tick(en, d, st, vw, lk);
      end
    end
  endtask

  initial begin
    rst_a = 1; rst_b = 1;
    digit = 0; enter = 0; set_pass = 0; view_pass = 0; lock = 0;

    // default configuration
    sel = 0; N = 4; W = 4; MAXA = 3; LCK = 16; DEF = 64'h1234;
    run_directed();
    // change password, relock, old fails, new unlocks
    tick(0, 0, 1, 0, 0);
    enter_seq(64'h5678);
    cmp("setnew.back_unlocked", 64'(o_g), 64'(1));
    tick(0, 0, 0, 1, 0);
    cmp("setnew.view", o_vp, 64'h5678);
    tick(0, 0, 0, 0, 1);
    enter_seq(64'h1234);
    tick(0, 0, 0, 0, 0);
    cmp("oldpass.att", 64'(o_at), 64'(2));
    cmp("oldpass.red", 64'(o_r), 64'(1));
    enter_seq(64'h5678);
    tick(0, 0, 0, 0, 0);
    cmp("newpass.green", 64'(o_g), 64'(1));
    // lock aborts SET_NEW and keeps the password
    tick(0, 0, 1, 0, 0);
    tick(1, 4'd1, 0, 0, 0);
    tick(1, 4'd2, 0, 0, 1);
    cmp("abort.red", 64'(o_r), 64'(1));
    enter_seq(64'h5678);
    tick(0, 0, 0, 0, 0);
    cmp("abort.keep_pass", 64'(o_g), 64'(1));
    // set_pass and lock together -> lock wins
    tick(0, 0, 1, 0, 1);
    cmp("prio.red",   64'(o_r), 64'(1));
    cmp("prio.green", 64'(o_g), 64'(0));
    // reset mid-entry restores the default password
    tick(1, 4'd1, 0, 0, 0);
    tick(1, 4'd2, 0, 0, 0);
    do_reset();
    enter_seq(64'h1234);
    tick(0, 0, 0, 0, 0);
    cmp("after_reset.unlock", 64'(o_g), 64'(1));
    run_random(400);

    // 6-digit, 2-attempt configuration
    rst_a = 1;
    sel = 1; N = 6; W = 4; MAXA = 2; LCK = 16; DEF = 64'h123456;
    run_directed();
    run_random(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
